// File: rtl/sparc_win_pkg.sv
// rtl/sparc_win_pkg.sv - shared op-codes, FSM encodings and sizing helpers for the window controller
package sparc_win_pkg;

  localparam logic [1:0] OP_SAVE    = 2'd0;
  localparam logic [1:0] OP_RESTORE = 2'd1;
  localparam logic [1:0] OP_TRAP    = 2'd2;
  localparam logic [1:0] OP_RETT    = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EVAL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // CWP width: clog2 of the window count, never narrower than one bit
  function automatic int cwpWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Mask selecting the implemented WIM bits
  function automatic logic [31:0] wimMask(input int n);
    return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

endpackage

// File: rtl/window_mod.sv
// rtl/window_mod.sv - modulo-NWINDOWS increment/decrement of a window pointer
module window_mod
  import sparc_win_pkg::*;
#(
  parameter int  NWINDOWS = 8,
  localparam int CWP_W    = cwpWidth(NWINDOWS)
) (
  input  logic [CWP_W-1:0] value,
  input  logic             dir,     // 1 = increment, 0 = decrement
  output logic [CWP_W-1:0] result
);

  localparam logic [CWP_W-1:0] LAST = CWP_W'(NWINDOWS - 1);

  // Explicit wrap compares keep non-power-of-2 window counts correct
  always_comb begin
    result = value;
    if (dir) result = (value == LAST)   ? '0   : value + CWP_W'(1);
    else     result = (value == '0)     ? LAST : value - CWP_W'(1);
  end

endmodule

// File: rtl/window_ctrl.sv
// rtl/window_ctrl.sv - register-window pointer and invalid-mask controller with trap counters
module window_ctrl
  import sparc_win_pkg::*;
#(
  parameter int          NWINDOWS = 8,
  parameter logic [31:0] WIM_RST  = 32'h0000_0002,
  localparam int         CWP_W    = cwpWidth(NWINDOWS)
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  output logic             op_ready,
  output logic             done,
  output logic             overflow,
  output logic             underflow,
  input  logic             wim_we,
  input  logic [31:0]      wim_din,
  input  logic             cwp_we,
  input  logic [CWP_W-1:0] cwp_din,
  output logic [CWP_W-1:0] cwp_out,
  output logic [31:0]      wim_out,
  output logic [15:0]      ovf_cnt,
  output logic [15:0]      unf_cnt
);

  localparam logic [31:0]    WIM_MASK = wimMask(NWINDOWS);
  localparam logic [CWP_W:0] NW_EXT   = (CWP_W + 1)'(NWINDOWS);

  logic [1:0]       state;
  logic [1:0]       opReg;
  logic [CWP_W-1:0] cwpReg;
  logic [CWP_W-1:0] nxt;
  logic [CWP_W-1:0] cwpLoad;
  logic [31:0]      wimReg;
  logic             ovfReg;
  logic             unfReg;
  logic [15:0]      ovfCnt;
  logic [15:0]      unfCnt;
  logic             isDec;
  logic             hit;
  logic             trapOvf;
  logic             trapUnf;

  assign isDec   = (opReg == OP_SAVE) || (opReg == OP_TRAP);
  assign hit     = wimReg[nxt];
  assign trapOvf = (opReg == OP_SAVE) && hit;
  assign trapUnf = ((opReg == OP_RESTORE) || (opReg == OP_RETT)) && hit;
  // cwp_din is below 2*NWINDOWS, so one conditional subtract is a full modulo
  assign cwpLoad = ({1'b0, cwp_din} >= NW_EXT) ? cwp_din - NW_EXT[CWP_W-1:0] : cwp_din;

  window_mod #(.NWINDOWS(NWINDOWS)) uMod (
    .value  (cwpReg),
    .dir    (~isDec),
    .result (nxt)
  );

  // Operation sequencer: latch op-code on accept, evaluate, then report
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state <= ST_IDLE;
      opReg <= OP_SAVE;
    end else begin
      case (state)
        ST_IDLE: if (op_valid) begin
          state <= ST_EVAL;
          opReg <= op_code;
        end
        ST_EVAL: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Trap flags are registered on the EVAL edge so they live only in DONE
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      ovfReg <= 1'b0;
      unfReg <= 1'b0;
    end else begin
      ovfReg <= (state == ST_EVAL) && trapOvf;
      unfReg <= (state == ST_EVAL) && trapUnf;
    end
  end

  // Window pointer: a direct write overrides an operation commit on the same edge
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr)                                          cwpReg <= '0;
    else if (cwp_we)                                   cwpReg <= cwpLoad;
    else if ((state == ST_EVAL) && !(trapOvf || trapUnf)) cwpReg <= nxt;
  end

  // Invalid-window mask: unimplemented windows are forced to zero
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr)        wimReg <= WIM_RST & WIM_MASK;
    else if (wim_we) wimReg <= wim_din & WIM_MASK;
  end

  // Saturating trap counters, bumped once per completion carrying a flag
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      ovfCnt <= '0;
      unfCnt <= '0;
    end else if (state == ST_DONE) begin
      if (ovfReg && (ovfCnt != 16'hFFFF)) ovfCnt <= ovfCnt + 16'd1;
      if (unfReg && (unfCnt != 16'hFFFF)) unfCnt <= unfCnt + 16'd1;
    end
  end

  assign op_ready  = (state == ST_IDLE);
  assign done      = (state == ST_DONE);
  assign overflow  = ovfReg;
  assign underflow = unfReg;
  assign cwp_out   = cwpReg;
  assign wim_out   = wimReg;
  assign ovf_cnt   = ovfCnt;
  assign unf_cnt   = unfCnt;

endmodule

// File: tb/tb_window_ctrl.sv
// tb/tb_window_ctrl.sv - directed self-checking bench for window_ctrl (8- and 5-window instances)
module tb_window_ctrl;
  import sparc_win_pkg::*;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic Clr;

  logic        v8, rdy8, dn8, ov8, un8, wwe8, cwe8;
  logic [1:0]  c8;
  logic [31:0] wdin8, wout8;
  logic [2:0]  cdin8, cout8;
  logic [15:0] oc8, uc8;

  logic        v5, rdy5, dn5, ov5, un5, wwe5, cwe5;
  logic [1:0]  c5;
  logic [31:0] wdin5, wout5;
  logic [2:0]  cdin5, cout5;
  logic [15:0] oc5, uc5;

  int errors = 0;
  int checks = 0;

  window_ctrl #(.NWINDOWS(8)) dut8 (
    .Clk(Clk), .Clr(Clr), .op_valid(v8), .op_code(c8), .op_ready(rdy8), .done(dn8),
    .overflow(ov8), .underflow(un8), .wim_we(wwe8), .wim_din(wdin8), .cwp_we(cwe8),
    .cwp_din(cdin8), .cwp_out(cout8), .wim_out(wout8), .ovf_cnt(oc8), .unf_cnt(uc8)
  );

  window_ctrl #(.NWINDOWS(5)) dut5 (
    .Clk(Clk), .Clr(Clr), .op_valid(v5), .op_code(c5), .op_ready(rdy5), .done(dn5),
    .overflow(ov5), .underflow(un5), .wim_we(wwe5), .wim_din(wdin5), .cwp_we(cwe5),
    .cwp_din(cdin5), .cwp_out(cout5), .wim_out(wout5), .ovf_cnt(oc5), .unf_cnt(uc5)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic runOp(input bit on5, input logic [1:0] op, input logic expOvf,
                       input logic expUnf, input logic [2:0] expCwp, input string tag);
    @(negedge Clk);
    if (on5) begin v5 = 1'b1; c5 = op; end
    else     begin v8 = 1'b1; c8 = op; end
    @(negedge Clk);
    v5 = 1'b0; v8 = 1'b0;
    chk({tag, ".evalDone"}, on5 ? dn5 : dn8, 0);
    @(negedge Clk);
    chk({tag, ".done"}, on5 ? dn5 : dn8, 1);
    chk({tag, ".ovf"},  on5 ? ov5 : ov8, expOvf);
    chk({tag, ".unf"},  on5 ? un5 : un8, expUnf);
    chk({tag, ".cwp"},  on5 ? cout5 : cout8, expCwp);
    @(negedge Clk);
    chk({tag, ".doneLow"}, on5 ? dn5 : dn8, 0);
    chk({tag, ".ready"},   on5 ? rdy5 : rdy8, 1);
  endtask

  task automatic wrCwp(input bit on5, input logic [2:0] val);
    @(negedge Clk);
    if (on5) begin cwe5 = 1'b1; cdin5 = val; end
    else     begin cwe8 = 1'b1; cdin8 = val; end
    @(negedge Clk);
    cwe5 = 1'b0; cwe8 = 1'b0;
  endtask

  task automatic wrWim(input bit on5, input logic [31:0] val);
    @(negedge Clk);
    if (on5) begin wwe5 = 1'b1; wdin5 = val; end
    else     begin wwe8 = 1'b1; wdin8 = val; end
    @(negedge Clk);
    wwe5 = 1'b0; wwe8 = 1'b0;
  endtask

  logic [2:0] saveCwp [8] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd2, 3'd2};

  initial begin
    Clr = 1'b0;
    v8 = 0; c8 = 0; wwe8 = 0; wdin8 = 0; cwe8 = 0; cdin8 = 0;
    v5 = 0; c5 = 0; wwe5 = 0; wdin5 = 0; cwe5 = 0; cdin5 = 0;
    #12;
    chk("rst.cwp", cout8, 0);
    chk("rst.wim", wout8, 32'h2);
    chk("rst.done", dn8, 0);
    chk("rst.flags", {ov8, un8}, 0);
    chk("rst.cnts", {oc8, uc8}, 0);
    chk("rst.ready", rdy8, 1);
    chk("rst.wim5", wout5, 32'h2);
    @(negedge Clk);
    Clr = 1'b1;

    // Eight SAVEs walking down into the invalid window 1
    for (int i = 0; i < 8; i++) begin
      runOp(0, OP_SAVE, (i >= 6), 1'b0, saveCwp[i], $sformatf("save%0d", i));
      if (i == 6) chk("save.ovfCnt1", oc8, 1);
    end
    chk("save.ovfCnt2", oc8, 2);

    // RESTORE from 0 hits window 1; TRAP_ENTRY ignores WIM
    wrCwp(0, 3'd0);
    runOp(0, OP_RESTORE, 1'b0, 1'b1, 3'd0, "restore");
    chk("restore.unfCnt", uc8, 1);
    runOp(0, OP_TRAP, 1'b0, 1'b0, 3'd7, "trap");

    // WIM write on the EVAL edge: old mask is used; a valid held in EVAL is ignored
    wrCwp(0, 3'd3);
    @(negedge Clk);
    v8 = 1'b1; c8 = OP_SAVE;
    @(negedge Clk);
    wwe8 = 1'b1; wdin8 = 32'hFFFF_FF04;
    @(negedge Clk);
    wwe8 = 1'b0; v8 = 1'b0;
    chk("wimRace.done", dn8, 1);
    chk("wimRace.ovf", ov8, 0);
    chk("wimRace.cwp", cout8, 2);
    chk("wimRace.wim", wout8, 32'h04);
    @(negedge Clk);
    @(negedge Clk);
    chk("noQueue.done", dn8, 0);
    chk("noQueue.cwp", cout8, 2);
    runOp(0, OP_SAVE, 1'b0, 1'b0, 3'd1, "saveAfterWim");

    // cwp_we collides with an underflowing RESTORE commit
    @(negedge Clk);
    v8 = 1'b1; c8 = OP_RESTORE;
    @(negedge Clk);
    v8 = 1'b0; cwe8 = 1'b1; cdin8 = 3'd5;
    @(negedge Clk);
    cwe8 = 1'b0;
    chk("cwpRace.done", dn8, 1);
    chk("cwpRace.unf", un8, 1);
    chk("cwpRace.cwp", cout8, 5);
    @(negedge Clk);
    chk("cwpRace.unfCnt", uc8, 2);

    // Reset during EVAL aborts the operation
    @(negedge Clk);
    v8 = 1'b1; c8 = OP_SAVE;
    @(negedge Clk);
    v8 = 1'b0; Clr = 1'b0;
    #1;
    chk("abort.done", dn8, 0);
    chk("abort.cwp", cout8, 0);
    chk("abort.wim", wout8, 32'h2);
    chk("abort.cnts", {oc8, uc8}, 0);
    @(negedge Clk);
    chk("abort.doneHeld", dn8, 0);
    Clr = 1'b1;
    @(negedge Clk);
    chk("abort.ready", rdy8, 1);
    chk("abort.doneAfter", dn8, 0);

    // Five windows: non-power-of-2 wrap both ways and modulo on CWP write
    wrWim(1, 32'h0);
    wrCwp(1, 3'd4);
    chk("nw5.cwpWr", cout5, 4);
    runOp(1, OP_RESTORE, 1'b0, 1'b0, 3'd0, "nw5.restore");
    runOp(1, OP_SAVE, 1'b0, 1'b0, 3'd4, "nw5.save");
    wrCwp(1, 3'd6);
    chk("nw5.cwpMod", cout5, 1);
    runOp(1, OP_RETT, 1'b0, 1'b0, 3'd2, "nw5.rett");

    // Overflow counter saturation, preloaded just below the ceiling
    wrCwp(0, 3'd2);
    @(negedge Clk);
    force dut8.ovfCnt = 16'hFFFE;
    @(negedge Clk);
    release dut8.ovfCnt;
    @(negedge Clk);
    chk("sat.preload", oc8, 16'hFFFE);
    runOp(0, OP_SAVE, 1'b1, 1'b0, 3'd2, "sat1");
    chk("sat.ffff", oc8, 16'hFFFF);
    runOp(0, OP_SAVE, 1'b1, 1'b0, 3'd2, "sat2");
    chk("sat.hold", oc8, 16'hFFFF);
    chk("sat.unf", uc8, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/window_ctrl.md
WINDOW_CTRL -- requirements
Module: window_ctrl

Interface
REQ-001 Parameter NWINDOWS, default 8, number of register windows; legal range 2..32.
REQ-002 Parameter WIM_RST, default 32'h0000_0002, WIM reset image; bits >= NWINDOWS are ignored.
REQ-003 Localparam CWP_W, equal to clog2(NWINDOWS) with a minimum of 1, is the CWP width.
REQ-004 Clk  in  1  single clock; all state updates on rising edge.
REQ-005 Clr  in  1  reset, asynchronous, active-low.
REQ-006 op_valid  in  1  window-operation request.
REQ-007 op_code  in  2  operation: 0=SAVE, 1=RESTORE, 2=TRAP_ENTRY, 3=RETT.
REQ-008 op_ready  out  1  high only in IDLE; a request is accepted when op_valid and op_ready are both high.
REQ-009 done  out  1  one-cycle pulse marking operation completion.
REQ-010 overflow  out  1  valid with done; SAVE hit an invalid window.
REQ-011 underflow  out  1  valid with done; RESTORE/RETT hit an invalid window.
REQ-012 wim_we  in  1  WIM write strobe (WRWIM).
REQ-013 wim_din  in  32  WIM write data.
REQ-014 cwp_we  in  1  CWP write strobe (WRPSR).
REQ-015 cwp_din  in  CWP_W  CWP write data.
REQ-016 cwp_out  out  CWP_W  current window pointer.
REQ-017 wim_out  out  32  WIM; bits >= NWINDOWS always read 0.
REQ-018 ovf_cnt  out  16  saturating overflow trap count.
REQ-019 unf_cnt  out  16  saturating underflow trap count.

Function
REQ-020 The FSM SHALL have states IDLE, EVAL and DONE: IDLE->EVAL on accept, EVAL->DONE unconditionally, DONE->IDLE unconditionally.
REQ-021 The block SHALL register op_code on accept and SHALL pulse done in the DONE state, 2 cycles after the accepting edge.
REQ-022 In EVAL, the block SHALL compute nxt = (cwp-1) mod NWINDOWS for SAVE/TRAP_ENTRY and nxt = (cwp+1) mod NWINDOWS for RESTORE/RETT.
REQ-023 The wrap rules SHALL be: decrement of 0 gives NWINDOWS-1; increment of NWINDOWS-1 gives 0; this holds for NWINDOWS that are not a power of 2.
REQ-024 SAVE: if wim[nxt]=1, the block SHALL set overflow and leave cwp unchanged; otherwise it SHALL set cwp=nxt.
REQ-025 RESTORE/RETT: if wim[nxt]=1, the block SHALL set underflow and leave cwp unchanged; otherwise it SHALL set cwp=nxt.
REQ-026 TRAP_ENTRY SHALL always set cwp=nxt with no WIM check, and overflow and underflow SHALL be 0.
REQ-027 The cwp update and the trap flags SHALL become visible in DONE; overflow and underflow SHALL be 0 whenever done=0.
REQ-028 The WIM check SHALL use the WIM value present in the EVAL cycle.
REQ-029 wim_we SHALL load wim_din[NWINDOWS-1:0] next edge in any state; upper bits are discarded.
REQ-030 On the same edge, wim_we and the EVAL-cycle check: the check SHALL use the old WIM, and the new WIM SHALL apply afterwards.
REQ-031 cwp_we SHALL load cwp_din next edge; values >= NWINDOWS SHALL be reduced modulo NWINDOWS.
REQ-032 cwp_we and an operation commit on the same edge: cwp_we SHALL win and the operation's cwp update is dropped, but its trap flags and done are still produced.
REQ-033 ovf_cnt and unf_cnt SHALL increment by 1 on each done carrying the respective flag and SHALL saturate at 16'hFFFF.
REQ-034 op_valid outside IDLE SHALL be ignored (no queuing).

Reset
REQ-035 When Clr=0, asynchronously: state=IDLE, cwp_out=0, wim_out=WIM_RST masked to NWINDOWS bits, done=0, overflow=0, underflow=0, ovf_cnt=0, unf_cnt=0.
REQ-036 Clr asserted mid-operation SHALL abort it with no done pulse; op_ready SHALL be high on the first edge after Clr rises.

Structure
REQ-037 Op-code constants and FSM state encodings SHALL reside in shared package sparc_win_pkg.
REQ-038 Modular increment/decrement SHALL be one sub-module window_mod (parameter NWINDOWS; inputs value and dir; output result), instantiated once.
REQ-039 Synthesizable RTL, no latches, single clock domain.

Verification
REQ-040 NWINDOWS=8, reset, WIM=0x02: 8 SAVEs -> done each time 2 cycles after accept; first SAVE gives cwp=7 with no flag; cwp then steps 7,6,5,4,3,2; the SAVE at cwp=2 (nxt=1) gives overflow=1, cwp stays 2, ovf_cnt=1.
REQ-041 NWINDOWS=8, cwp=0, WIM=0x02: RESTORE -> underflow=1, cwp=0; then TRAP_ENTRY -> cwp=7 with no flags.
REQ-042 NWINDOWS=5, cwp written to 4, WIM=0: RESTORE -> cwp=0; SAVE -> cwp=4; write cwp_din=6 -> cwp=1.
REQ-043 NWINDOWS=8, cwp=3: SAVE accepted, wim_we=0x04 on the EVAL edge -> no overflow (old WIM used), cwp=2; the following SAVE -> cwp=1.
REQ-044 Clr pulled low during EVAL -> no done pulse, cwp=0, wim=0x02; op_ready=1 one cycle after release.
REQ-045 Force 65536 overflows -> ovf_cnt holds at 16'hFFFF.
